// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared types and constants for the write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

  localparam int         DEF_FIFO_DEPTH   = 2;
  localparam int         DEF_STARVE_LIMIT = 4;
  localparam logic [4:0] REG_ZERO         = 5'd0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        killed;
  } wb_entry_t;

  // One-hot register mask; x0 never contributes.
  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    logic [31:0] m;
    m    = 32'd1 << rd;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_fifo
// Purpose  : MDU result buffer with kill-by-rd and registered pending mask.
// Revision : 1.0 - initial release
// ============================================================================
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  wb_entry_t   i_push_entry,
  input  logic        i_pop,
  input  logic        i_kill_en,
  input  logic [4:0]  i_kill_rd,
  output wb_entry_t   o_head,
  output logic        o_empty,
  output logic        o_full,
  output logic [31:0] o_pending_mask
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [31:0]      r_mask;

  wb_entry_t        w_mem_n [DEPTH];
  logic [DEPTH-1:0] w_vld_n;
  logic [31:0]      w_mask_n;
  logic             w_push;
  logic             w_pop;

  assign o_empty        = (r_count == '0);
  assign o_full         = (r_count == (PTR_W+1)'(DEPTH));
  assign o_head         = r_mem[r_rd_ptr];
  assign o_pending_mask = r_mask;
  assign w_push         = i_push && !o_full;
  assign w_pop          = i_pop && !o_empty;

  // Kill is applied after the push so a same-cycle accept is also covered.
  always_comb begin
    w_mask_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_n[i] = r_mem[i];
      w_vld_n[i] = r_vld[i];
      if (w_pop && (r_rd_ptr == PTR_W'(i))) w_vld_n[i] = 1'b0;
      if (w_push && (r_wr_ptr == PTR_W'(i))) begin
        w_vld_n[i] = 1'b1;
        w_mem_n[i] = i_push_entry;
      end
      if (i_kill_en && w_vld_n[i] && (w_mem_n[i].rd == i_kill_rd))
        w_mem_n[i].killed = 1'b1;
      if (w_vld_n[i] && !w_mem_n[i].killed)
        w_mask_n = w_mask_n | rd_onehot(w_mem_n[i].rd);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      r_mask   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= w_mem_n[i];
      r_vld  <= w_vld_n;
      r_mask <= w_mask_n;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Register-file write-port arbiter between WriteBack and the MDU.
//            Starvation guard enabled by defining WB_ARB_STARVE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Ctl_RegWrite_in,
  input  logic [4:0]  Rd_in,
  input  logic [31:0] WBdata_in,
  input  logic        MDU_valid_in,
  input  logic [4:0]  MDU_Rd_in,
  input  logic [31:0] MDU_result_in,
  output logic        MDU_ready_out,
  output logic        Stall_out,
  output logic [31:0] Pending_mask_out,
  output logic        Ctl_RegWrite_out,
  output logic [4:0]  Rd_out,
  output logic [31:0] WriteDatatoReg_out
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  wb_entry_t   w_head;
  wb_entry_t   w_push_entry;
  logic        w_empty;
  logic        w_full;
  logic        w_stall;
  logic        w_pipe_eff;
  logic        w_push;
  logic        w_pop;
  logic        w_wr_en;
  logic [4:0]  w_wr_rd;
  logic [31:0] w_wr_data;

  logic        r_wr_en;
  logic [4:0]  r_wr_rd;
  logic [31:0] r_wr_data;

  assign MDU_ready_out = !reset && !w_full;
  assign w_pipe_eff    = Ctl_RegWrite_in && (Rd_in != REG_ZERO) && !w_stall;
  // x0 results are accepted but never buffered.
  assign w_push        = MDU_valid_in && MDU_ready_out && (MDU_Rd_in != REG_ZERO);
  assign w_push_entry  = '{rd: MDU_Rd_in, data: MDU_result_in, killed: 1'b0};

  always_comb begin
    w_pop     = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_rd   = REG_ZERO;
    w_wr_data = '0;
    if (w_stall || (!w_pipe_eff && !w_empty)) begin
      w_pop = 1'b1;
      if (!w_head.killed) begin
        w_wr_en   = 1'b1;
        w_wr_rd   = w_head.rd;
        w_wr_data = w_head.data;
      end
    end else if (w_pipe_eff) begin
      w_wr_en   = 1'b1;
      w_wr_rd   = Rd_in;
      w_wr_data = WBdata_in;
    end
  end

`ifdef WB_ARB_STARVE_EN
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [AGE_W-1:0] r_age;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_age <= '0;
    end else if (w_pop) begin
      r_age <= '0;
    end else if (!w_empty && (r_age != AGE_W'(STARVE_LIMIT))) begin
      r_age <= r_age + AGE_W'(1);
    end
  end

  assign w_stall = !w_empty && (r_age == AGE_W'(STARVE_LIMIT));
`else
  assign w_stall = 1'b0;
`endif

  assign Stall_out = w_stall;

  wb_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .i_push         (w_push),
    .i_push_entry   (w_push_entry),
    .i_pop          (w_pop),
    .i_kill_en      (w_pipe_eff),
    .i_kill_rd      (Rd_in),
    .o_head         (w_head),
    .o_empty        (w_empty),
    .o_full         (w_full),
    .o_pending_mask (Pending_mask_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_rd   <= REG_ZERO;
      r_wr_data <= '0;
    end else begin
      r_wr_en   <= w_wr_en;
      r_wr_rd   <= w_wr_rd;
      r_wr_data <= w_wr_data;
    end
  end

  assign Ctl_RegWrite_out   = r_wr_en;
  assign Rd_out             = r_wr_rd;
  assign WriteDatatoReg_out = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Self-checking bench: directed table, starvation sequence and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        Ctl_RegWrite_in;
  logic [4:0]  Rd_in;
  logic [31:0] WBdata_in;
  logic        MDU_valid_in;
  logic [4:0]  MDU_Rd_in;
  logic [31:0] MDU_result_in;
  logic        MDU_ready_out;
  logic        Stall_out;
  logic [31:0] Pending_mask_out;
  logic        Ctl_RegWrite_out;
  logic [4:0]  Rd_out;
  logic [31:0] WriteDatatoReg_out;

  wb_port_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .Ctl_RegWrite_in    (Ctl_RegWrite_in),
    .Rd_in              (Rd_in),
    .WBdata_in          (WBdata_in),
    .MDU_valid_in       (MDU_valid_in),
    .MDU_Rd_in          (MDU_Rd_in),
    .MDU_result_in      (MDU_result_in),
    .MDU_ready_out      (MDU_ready_out),
    .Stall_out          (Stall_out),
    .Pending_mask_out   (Pending_mask_out),
    .Ctl_RegWrite_out   (Ctl_RegWrite_out),
    .Rd_out             (Rd_out),
    .WriteDatatoReg_out (WriteDatatoReg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] rd,
                       input logic [31:0] data, input logic mv, input logic [4:0] mrd,
                       input logic [31:0] mres);
    reset           = rst;
    Ctl_RegWrite_in = we;
    Rd_in           = rd;
    WBdata_in       = data;
    MDU_valid_in    = mv;
    MDU_Rd_in       = mrd;
    MDU_result_in   = mres;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        ewe;
    logic [4:0]  erd;
    logic [31:0] edata;
    logic [31:0] emask;
    logic        erdy;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] rd,
                              input logic [31:0] data, input logic mv, input logic [4:0] mrd,
                              input logic [31:0] mres, input logic ewe, input logic [4:0] erd,
                              input logic [31:0] edata, input logic [31:0] emask,
                              input logic erdy);
    vec_t v;
    v.rst = rst;  v.we = we;   v.rd = rd;     v.data = data;
    v.mv = mv;    v.mrd = mrd; v.mres = mres;
    v.ewe = ewe;  v.erd = erd; v.edata = edata; v.emask = emask; v.erdy = erdy;
    return v;
  endfunction

  // Reference model: the buffer is a queue of pending results in arrival order.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          killed;
  } ent_t;

  ent_t        mq[$];
  int          m_age;
  logic        e_we;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[k]) if (!mq[k].killed) m[mq[k].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic bit model_stall();
    return STARVE && (mq.size() > 0) && (m_age == LIMIT);
  endfunction

  task automatic model_step();
    int   pre_n;
    bit   stall;
    bit   pipe;
    bit   pop;
    ent_t h;
    if (reset) begin
      mq.delete();
      m_age  = 0;
      e_we   = 1'b0;
      e_rd   = 5'd0;
      e_data = 32'd0;
      return;
    end
    pre_n  = mq.size();
    stall  = model_stall();
    pipe   = Ctl_RegWrite_in && (Rd_in != 5'd0) && !stall;
    pop    = stall || (!pipe && pre_n > 0);
    e_we   = 1'b0;
    e_rd   = 5'd0;
    e_data = 32'd0;
    if (pop) begin
      h = mq.pop_front();
      if (!h.killed) begin
        e_we = 1'b1; e_rd = h.rd; e_data = h.data;
      end
    end else if (pipe) begin
      e_we = 1'b1; e_rd = Rd_in; e_data = WBdata_in;
    end
    if (pipe) foreach (mq[k]) if (mq[k].rd == Rd_in) mq[k].killed = 1'b1;
    if (MDU_valid_in && (pre_n < DEPTH) && (MDU_Rd_in != 5'd0)) begin
      h.rd = MDU_Rd_in; h.data = MDU_result_in; h.killed = pipe && (MDU_Rd_in == Rd_in);
      mq.push_back(h);
    end
    if (pop) m_age = 0;
    else if (pre_n > 0 && m_age < LIMIT) m_age++;
  endtask

  vec_t tbl[15];

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    //          rst   we    rd     data          mv    mrd    mres           ewe   erd    edata         emask          erdy
    tbl[0]  = mk(1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'h0,         1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h1234,     1'b0, 5'd0, 32'h0,        32'h0000_0020, 1'b1);
    tbl[2]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h1234,     32'h0,         1'b1);
    tbl[3]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'h0,         1'b1);
    tbl[4]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h55,       1'b0, 5'd0, 32'h0,        32'h0000_0200, 1'b1);
    tbl[5]  = mk(1'b0, 1'b1, 5'd9, 32'hAA,       1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hAA,       32'h0,         1'b1);
    tbl[6]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'h0,         1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,        32'h0000_0010, 1'b1);
    tbl[8]  = mk(1'b0, 1'b1, 5'd0, 32'hDEAD,     1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h44,       32'h0,         1'b1);
    tbl[9]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 32'h1,        1'b0, 5'd0, 32'h0,        32'h0000_0040, 1'b1);
    tbl[10] = mk(1'b0, 1'b1, 5'd3, 32'h3,        1'b1, 5'd7, 32'h2,        1'b1, 5'd3, 32'h3,        32'h0000_00C0, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'h0,         1'b0);
    tbl[12] = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'h0,         1'b1);
    tbl[13] = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h9,        1'b0, 5'd0, 32'h0,        32'h0,         1'b1);
    tbl[14] = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'h0,         1'b1);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].rd, tbl[i].data, tbl[i].mv, tbl[i].mrd, tbl[i].mres);
      step();
      chk($sformatf("t%0d_we", i),    32'(Ctl_RegWrite_out), 32'(tbl[i].ewe));
      chk($sformatf("t%0d_rd", i),    32'(Rd_out),           32'(tbl[i].erd));
      chk($sformatf("t%0d_data", i),  WriteDatatoReg_out,    tbl[i].edata);
      chk($sformatf("t%0d_mask", i),  Pending_mask_out,      tbl[i].emask);
      chk($sformatf("t%0d_ready", i), 32'(MDU_ready_out),    32'(tbl[i].erdy));
      chk($sformatf("t%0d_stall", i), 32'(Stall_out),        32'd0);
    end

    // Pipeline hogs the port while one MDU result waits.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    step();
    chk("hog_first_rd", 32'(Rd_out), 32'd3);
    chk("hog_mask7", Pending_mask_out, 32'h0000_0080);
`ifdef WB_ARB_STARVE_EN
    MDU_valid_in = 1'b0;
    for (int k = 1; k <= LIMIT; k++) begin
      step();
      chk($sformatf("hog_stall_c%0d", k), 32'(Stall_out), (k == LIMIT) ? 32'd1 : 32'd0);
      chk($sformatf("hog_rd_c%0d", k), 32'(Rd_out), 32'd3);
    end
    step();
    chk("hog_drain_we", 32'(Ctl_RegWrite_out), 32'd1);
    chk("hog_drain_rd", 32'(Rd_out), 32'd7);
    chk("hog_drain_data", WriteDatatoReg_out, 32'h77);
    chk("hog_stall_clear", 32'(Stall_out), 32'd0);
`else
    drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h88);
    step();
    chk("hog_full_ready", 32'(MDU_ready_out), 32'd0);
    MDU_valid_in = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      step();
      chk($sformatf("hog_ready_c%0d", k), 32'(MDU_ready_out), 32'd0);
      chk($sformatf("hog_stall_c%0d", k), 32'(Stall_out), 32'd0);
    end
    Ctl_RegWrite_in = 1'b0;
    step();
    chk("hog_drain_rd", 32'(Rd_out), 32'd7);
    chk("hog_drain_data", WriteDatatoReg_out, 32'h77);
    chk("hog_ready_back", 32'(MDU_ready_out), 32'd1);
`endif

    // Randomized traffic against the queue model.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    model_step();
    step();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(99, 0) == 0),
            ($urandom_range(1, 0) == 1), 5'($urandom_range(7, 0)), $urandom(),
            ($urandom_range(2, 0) != 0), 5'($urandom_range(7, 0)), $urandom());
      model_step();
      step();
      chk($sformatf("r%0d_we", n),    32'(Ctl_RegWrite_out), 32'(e_we));
      chk($sformatf("r%0d_rd", n),    32'(Rd_out),           32'(e_rd));
      chk($sformatf("r%0d_data", n),  WriteDatatoReg_out,    e_data);
      chk($sformatf("r%0d_mask", n),  Pending_mask_out,      model_mask());
      chk($sformatf("r%0d_ready", n), 32'(MDU_ready_out),
          32'(!reset && (mq.size() < DEPTH)));
      chk($sformatf("r%0d_stall", n), 32'(Stall_out),        32'(model_stall()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
